// File: rtl/rv32i_types.sv
// Shared types for the RV32 back-end reservation stations: MDU opcodes and the
// station entry layout, plus the CDB snoop used for both dispatch bypass and wakeup.
package rv32i_types;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_t;

    // Tags are stored at a fixed maximum width so the struct can live in the
    // package; stations zero-extend their TAG_W tags into it.
    localparam int RVS_TAG_W_MAX = 8;

    typedef struct packed {
        logic                     rdy;
        logic [31:0]              val;
        logic [RVS_TAG_W_MAX-1:0] ptag;
    } rvs_src_t;

    typedef struct packed {
        logic                     valid;
        mdu_op_t                  opc;
        logic [RVS_TAG_W_MAX-1:0] tag;
        rvs_src_t                 src1;
        rvs_src_t                 src2;
    } rvs_entry_t;

    function automatic rvs_src_t src_snoop(input rvs_src_t                 s,
                                           input logic                     cvld,
                                           input logic [RVS_TAG_W_MAX-1:0] ctag,
                                           input logic [31:0]              cdata);
        rvs_src_t r;
        r = s;
        if (!s.rdy && cvld && (s.ptag == ctag)) begin
            r.rdy = 1'b1;
            r.val = cdata;
        end
        return r;
    endfunction

endpackage

// File: rtl/rvs_age_sel.sv
// Oldest-ready picker for reservation stations: older_i[j][i]=1 means entry j
// is older than entry i; grants the one ready entry with no older ready entry.
module rvs_age_sel #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]            rdy_i,
    input  logic [DEPTH-1:0][DEPTH-1:0] older_i,
    output logic [DEPTH-1:0]            gnt_o
);

    always_comb begin
        gnt_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            gnt_o[i] = rdy_i[i];
            for (int j = 0; j < DEPTH; j++) begin
                if ((j != i) && rdy_i[j] && older_i[j][i]) begin
                    gnt_o[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/mdu_rvs.sv
// Reservation station in front of the MDU: holds dispatched mul/div ops until
// both operands arrive over the CDB, then issues the oldest ready one.
module mdu_rvs
    import rv32i_types::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     dis_req,
    output logic                     dis_rdy,
    input  logic [2:0]               dis_opc,
    input  logic [TAG_W-1:0]         dis_tag,
    input  logic                     dis_src1_rdy,
    input  logic [31:0]              dis_src1_val,
    input  logic [TAG_W-1:0]         dis_src1_tag,
    input  logic                     dis_src2_rdy,
    input  logic [31:0]              dis_src2_val,
    input  logic [TAG_W-1:0]         dis_src2_tag,
    input  logic                     cdb_vld,
    input  logic [TAG_W-1:0]         cdb_tag,
    input  logic [31:0]              cdb_wdata,
    output logic                     iss_req,
    input  logic                     iss_rdy,
    output logic [2:0]               iss_opc,
    output logic [31:0]              iss_src1,
    output logic [31:0]              iss_src2,
    output logic [TAG_W-1:0]         iss_tag,
    output logic [$clog2(DEPTH)+1-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    rvs_entry_t                ent_q [DEPTH];
    rvs_entry_t                ent_d [DEPTH];
    rvs_entry_t                new_ent;
    rvs_src_t                  dsrc1, dsrc2;
    logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [DEPTH-1:0]          rdy_vec, gnt, alloc_oh;
    logic [RVS_TAG_W_MAX-1:0]  cdb_tag_x;
    logic                      do_dis, do_iss;
    logic                      hold_q, sel_older;
    logic [DEPTH-1:0]          gnt_hold_q;

    assign cdb_tag_x = RVS_TAG_W_MAX'(cdb_tag);
    assign dis_rdy   = (count_q != CNT_W'(DEPTH));
    assign do_dis    = dis_req & dis_rdy;
    assign count     = count_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rdy_vec[i] = ent_q[i].valid & ent_q[i].src1.rdy & ent_q[i].src2.rdy;
        end
    end

    rvs_age_sel #(.DEPTH(DEPTH)) u_age_sel (
        .rdy_i   (rdy_vec),
        .older_i (older_q),
        .gnt_o   (gnt)
    );

    // Ops being reset or flushed away must never be handed to the MDU.
    assign iss_req = (|rdy_vec) & ~rst & ~flush;
    assign do_iss  = iss_req & iss_rdy;

    always_comb begin
        iss_opc  = '0;
        iss_src1 = '0;
        iss_src2 = '0;
        iss_tag  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            iss_opc  = iss_opc  | ({3{gnt[i]}}     & ent_q[i].opc);
            iss_src1 = iss_src1 | ({32{gnt[i]}}    & ent_q[i].src1.val);
            iss_src2 = iss_src2 | ({32{gnt[i]}}    & ent_q[i].src2.val);
            iss_tag  = iss_tag  | ({TAG_W{gnt[i]}} & ent_q[i].tag[TAG_W-1:0]);
        end
    end

    always_comb begin
        alloc_oh = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_q[i].valid) begin
                alloc_oh    = '0;
                alloc_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        dsrc1.rdy  = dis_src1_rdy;
        dsrc1.val  = dis_src1_val;
        dsrc1.ptag = RVS_TAG_W_MAX'(dis_src1_tag);
        dsrc2.rdy  = dis_src2_rdy;
        dsrc2.val  = dis_src2_val;
        dsrc2.ptag = RVS_TAG_W_MAX'(dis_src2_tag);
        new_ent       = '0;
        new_ent.valid = 1'b1;
        new_ent.opc   = mdu_op_t'(dis_opc);
        new_ent.tag   = RVS_TAG_W_MAX'(dis_tag);
        new_ent.src1  = src_snoop(dsrc1, cdb_vld, cdb_tag_x, cdb_wdata);
        new_ent.src2  = src_snoop(dsrc2, cdb_vld, cdb_tag_x, cdb_wdata);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].valid) begin
                ent_d[i].src1 = src_snoop(ent_q[i].src1, cdb_vld, cdb_tag_x, cdb_wdata);
                ent_d[i].src2 = src_snoop(ent_q[i].src2, cdb_vld, cdb_tag_x, cdb_wdata);
            end
            if (do_iss && gnt[i]) begin
                ent_d[i].valid = 1'b0;
            end
            if (do_dis && alloc_oh[i]) begin
                ent_d[i] = new_ent;
            end
        end
    end

    // A new entry is younger than every slot; stale rows of free slots are
    // harmless because the select only looks at ready (valid) entries.
    always_comb begin
        older_d = older_q;
        for (int k = 0; k < DEPTH; k++) begin
            if (do_dis && alloc_oh[k]) begin
                for (int j = 0; j < DEPTH; j++) begin
                    older_d[k][j] = 1'b0;
                    older_d[j][k] = (j != k);
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (do_dis && !do_iss) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_dis && do_iss) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            count_q <= count_d;
        end
        if (rst) begin
            older_q    <= '0;
            hold_q     <= 1'b0;
            gnt_hold_q <= '0;
        end else begin
            older_q    <= older_d;
            hold_q     <= iss_req & ~iss_rdy;
            gnt_hold_q <= gnt;
        end
    end

    always_comb begin
        sel_older = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (gnt[i] && |(older_q[i] & gnt_hold_q)) begin
                sel_older = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count_q <= CNT_W'(DEPTH));
            assert (!(do_dis && (alloc_oh == '0)));
            if (hold_q && !flush) begin
                assert (iss_req && ((gnt == gnt_hold_q) || sel_older));
            end
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = i + 1; j < DEPTH; j++) begin
                    if (ent_q[i].valid && ent_q[j].valid) begin
                        assert (ent_q[i].tag != ent_q[j].tag);
                    end
                end
            end
        end
    end

endmodule
